// File: rtl/trsq8_fetch.sv
// TRSQ8 instruction fetch stage: owns the PC and the return-address stack,
// registers ROM words for the decoder and applies jump/call/return redirects.
module trsq8_fetch #(
  parameter int unsigned  STACK_DEPTH  = 8,
  parameter logic [12:0]  RESET_VECTOR = 13'd0,
  localparam int unsigned PC_W         = 13,
  localparam int unsigned INSTR_W      = 15
) (
  input  logic               CLK_ip,
  input  logic               RST_ip,
  output logic [PC_W-1:0]    PROM_ADDR_op,
  input  logic [INSTR_W-1:0] PROM_DATA_ip,
  input  logic               STALL_ip,
  input  logic               JUMP_ip,
  input  logic               CALL_ip,
  input  logic               RET_ip,
  input  logic [PC_W-1:0]    JUMP_ADDR_ip,
  output logic [INSTR_W-1:0] INSTR_op,
  output logic [PC_W-1:0]    INSTR_PC_op,
  output logic               INSTR_VALID_op,
  output logic               STACK_ERR_op
);

  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned SP_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REFILL = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic [PC_W-1:0]    stack_q [STACK_DEPTH];

  logic               fetch_c;
  logic               redirect_c;
  logic               push_c;
  logic [IDX_W-1:0]   push_idx_c;
  logic [IDX_W-1:0]   pop_idx_c;
  logic [PC_W-1:0]    ret_addr_c;

  assign push_idx_c = sp_q[IDX_W-1:0];
  assign pop_idx_c  = IDX_W'(sp_q - SP_W'(1));
  assign ret_addr_c = instr_pc_q + PC_W'(1);

  // Next-state: fill, redirect (RET > CALL > JUMP), stall hold, or sequential fetch
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    err_d      = err_q;
    sp_d       = sp_q;
    fetch_c    = 1'b0;
    push_c     = 1'b0;
    redirect_c = valid_q && !STALL_ip && (RET_ip || CALL_ip || JUMP_ip);

    unique case (state_q)
      ST_FILL: fetch_c = 1'b1;
      ST_RUN, ST_REFILL: begin
        if (redirect_c) begin
          valid_d = 1'b0;
          state_d = ST_REFILL;
          if (RET_ip) begin
            if (sp_q == SP_W'(0)) begin
              pc_d  = RESET_VECTOR;
              err_d = 1'b1;
            end else begin
              pc_d = stack_q[pop_idx_c];
              sp_d = sp_q - SP_W'(1);
            end
          end else if (CALL_ip) begin
            pc_d = JUMP_ADDR_ip;
            if (sp_q == SP_W'(STACK_DEPTH)) begin
              err_d = 1'b1;
            end else begin
              push_c = 1'b1;
              sp_d   = sp_q + SP_W'(1);
            end
          end else begin
            pc_d = JUMP_ADDR_ip;
          end
        end else if (!STALL_ip) begin
          fetch_c = 1'b1;
        end
      end
      default: state_d = ST_FILL;
    endcase

    if (fetch_c) begin
      instr_d    = PROM_DATA_ip;
      instr_pc_d = pc_q;
      valid_d    = 1'b1;
      pc_d       = pc_q + PC_W'(1);
      state_d    = ST_RUN;
    end
  end

  always_ff @(posedge CLK_ip) begin
    if (RST_ip) begin
      state_q    <= ST_FILL;
      pc_q       <= RESET_VECTOR;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      sp_q       <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      sp_q       <= sp_d;
    end
  end

  // Stack contents need no reset: entries above the pointer are never read
  always_ff @(posedge CLK_ip) begin
    if (!RST_ip && push_c) begin
      stack_q[push_idx_c] <= ret_addr_c;
    end
  end

  assign PROM_ADDR_op   = pc_q;
  assign INSTR_op       = instr_q;
  assign INSTR_PC_op    = instr_pc_q;
  assign INSTR_VALID_op = valid_q;
  assign STACK_ERR_op   = err_q;

endmodule

// File: tb/tb_trsq8_fetch.sv
// Self-checking bench for trsq8_fetch: directed scenarios plus randomized
// traffic against a queue-based behavioural model of the fetch stage.
module tb_trsq8_fetch;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] prom_addr;
  logic [14:0] prom_data;
  logic        stall, jump, call, ret;
  logic [12:0] jaddr;
  logic [14:0] instr;
  logic [12:0] instr_pc;
  logic        valid, err;
  logic [14:0] rom_key;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [12:0] m_pc, m_ipc;
  logic [14:0] m_instr;
  logic        m_valid, m_err;
  bit          m_fill;
  logic [12:0] m_stack [$];

  always #5 clk = ~clk;

  assign prom_data = {2'b00, prom_addr} ^ rom_key;

  trsq8_fetch #(.STACK_DEPTH(DEPTH), .RESET_VECTOR(13'd0)) dut (
    .CLK_ip(clk), .RST_ip(rst), .PROM_ADDR_op(prom_addr), .PROM_DATA_ip(prom_data),
    .STALL_ip(stall), .JUMP_ip(jump), .CALL_ip(call), .RET_ip(ret),
    .JUMP_ADDR_ip(jaddr), .INSTR_op(instr), .INSTR_PC_op(instr_pc),
    .INSTR_VALID_op(valid), .STACK_ERR_op(err)
  );

  function automatic logic [14:0] rom_word(input logic [12:0] a);
    return {2'b00, a} ^ rom_key;
  endfunction

  task automatic model_fetch();
    m_instr = rom_word(m_pc);
    m_ipc   = m_pc;
    m_valid = 1'b1;
    m_pc    = m_pc + 13'd1;
  endtask

  // One clock edge of the reference behaviour, using the inputs held at the edge
  task automatic model_step();
    if (rst) begin
      m_pc = 13'd0; m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_err = 1'b0;
      m_fill = 1'b1;
      m_stack.delete();
    end else if (m_fill) begin
      model_fetch();
      m_fill = 1'b0;
    end else if (m_valid && !stall && (ret || call || jump)) begin
      if (ret) begin
        if (m_stack.size() == 0) begin
          m_pc = 13'd0; m_err = 1'b1;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end else if (call) begin
        if (m_stack.size() == DEPTH) m_err = 1'b1;
        else m_stack.push_back(m_ipc + 13'd1);
        m_pc = jaddr;
      end else begin
        m_pc = jaddr;
      end
      m_valid = 1'b0;
    end else if (!stall) begin
      model_fetch();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; jump = 1'b1; jaddr = 13'h0aa;
    tick(); tick();
    rst = 1'b0; stall = 1'b0; jump = 1'b0;
    n_checks++;
    if (prom_addr !== 13'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", prom_addr); end
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++;
    if (instr !== 15'h0 || instr_pc !== 13'h0) begin
      n_fail++; $display("FAIL reset_instr: got %h/%h want 0/0", instr, instr_pc);
    end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (instr_pc !== 13'(i) || instr !== 15'(i) || valid !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_instr[%0d]: got pc=%h instr=%h v=%b want pc=%h instr=%h v=1",
                 i, instr_pc, instr, valid, 13'(i), 15'(i));
      end
      n_checks++;
      if (prom_addr !== 13'(i + 1)) begin
        n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", i, prom_addr, 13'(i + 1));
      end
    end
  endtask

  task automatic test_stall();
    tick(); tick();
    n_checks++;
    if (instr_pc !== 13'h5) begin n_fail++; $display("FAIL stall_pre: got %h want 5", instr_pc); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // a redirect raised during stall must be ignored
      jump = (i == 1); jaddr = 13'h1aa;
      tick();
      n_checks++;
      if (prom_addr !== 13'h6 || instr_pc !== 13'h5 || instr !== 15'h5 || valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got addr=%h pc=%h instr=%h v=%b want 6/5/5/1",
                 i, prom_addr, instr_pc, instr, valid);
      end
    end
    jump = 1'b0; stall = 1'b0;
    tick();
    n_checks++;
    if (instr_pc !== 13'h6 || prom_addr !== 13'h7) begin
      n_fail++; $display("FAIL stall_release: got pc=%h addr=%h want 6/7", instr_pc, prom_addr);
    end
  endtask

  task automatic test_jump();
    tick();
    n_checks++;
    if (instr_pc !== 13'h7) begin n_fail++; $display("FAIL jump_pre: got %h want 7", instr_pc); end
    jump = 1'b1; jaddr = 13'h100;
    tick();
    jump = 1'b0;
    n_checks++;
    if (valid !== 1'b0 || prom_addr !== 13'h100) begin
      n_fail++; $display("FAIL jump_bubble: got v=%b addr=%h want 0/100", valid, prom_addr);
    end
    tick();
    n_checks++;
    if (instr_pc !== 13'h100 || valid !== 1'b1 || instr !== 15'h100) begin
      n_fail++;
      $display("FAIL jump_target: got pc=%h v=%b instr=%h want 100/1/100", instr_pc, valid, instr);
    end
  endtask

  task automatic test_call_ret();
    jump = 1'b1; jaddr = 13'h10;
    tick();
    jump = 1'b0;
    tick();
    n_checks++;
    if (instr_pc !== 13'h10) begin n_fail++; $display("FAIL call_pre: got %h want 10", instr_pc); end
    call = 1'b1; jaddr = 13'h200;
    tick();
    call = 1'b0;
    n_checks++;
    if (prom_addr !== 13'h200 || valid !== 1'b0) begin
      n_fail++; $display("FAIL call_redirect: got addr=%h v=%b want 200/0", prom_addr, valid);
    end
    tick(); tick();
    n_checks++;
    if (instr_pc !== 13'h201) begin n_fail++; $display("FAIL call_body: got %h want 201", instr_pc); end
    ret = 1'b1;
    tick();
    ret = 1'b0;
    n_checks++;
    if (prom_addr !== 13'h11 || valid !== 1'b0) begin
      n_fail++; $display("FAIL ret_redirect: got addr=%h v=%b want 11/0", prom_addr, valid);
    end
    tick();
    n_checks++;
    if (instr_pc !== 13'h11 || valid !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL ret_target: got pc=%h v=%b err=%b want 11/1/0", instr_pc, valid, err);
    end
  endtask

  task automatic test_nested();
    logic [12:0] exp_ret [DEPTH];
    logic [12:0] cur, tgt, want;
    cur = 13'h11;
    for (int k = 0; k < 9; k++) begin
      tgt = 13'h300 + 13'(k * 16);
      if (k < 8) exp_ret[k] = cur + 13'd1;
      call = 1'b1; jaddr = tgt;
      tick();
      call = 1'b0;
      n_checks++;
      if (prom_addr !== tgt || err !== (k == 8)) begin
        n_fail++;
        $display("FAIL nest_call[%0d]: got addr=%h err=%b want %h/%b", k, prom_addr, err, tgt, k == 8);
      end
      tick();
      cur = tgt;
    end
    for (int k = 0; k < 9; k++) begin
      want = (k < 8) ? exp_ret[7 - k] : 13'h0;
      ret = 1'b1;
      tick();
      ret = 1'b0;
      n_checks++;
      if (prom_addr !== want) begin
        n_fail++; $display("FAIL nest_ret[%0d]: got addr=%h want %h", k, prom_addr, want);
      end
      tick();
      n_checks++;
      if (instr_pc !== want || valid !== 1'b1 || err !== 1'b1) begin
        n_fail++;
        $display("FAIL nest_ret_fetch[%0d]: got pc=%h v=%b err=%b want %h/1/1", k, instr_pc, valid, err, want);
      end
    end
  endtask

  task automatic test_edge_cases();
    logic [14:0] exp_word;
    rom_key = 15'h5a3c;
    call = 1'b1; jaddr = 13'h400;
    tick();
    call = 1'b0;
    tick();
    // RET outranks JUMP when both are raised
    ret = 1'b1; jump = 1'b1; jaddr = 13'h555;
    tick();
    ret = 1'b0; jump = 1'b0;
    n_checks++;
    if (prom_addr !== 13'h1) begin n_fail++; $display("FAIL ret_over_jump: got %h want 1", prom_addr); end
    tick();
    exp_word = {2'b00, 13'h1} ^ 15'h5a3c;
    n_checks++;
    if (instr_pc !== 13'h1 || instr !== exp_word) begin
      n_fail++; $display("FAIL ret_over_jump_word: got pc=%h instr=%h want 1/%h", instr_pc, instr, exp_word);
    end
    jump = 1'b1; jaddr = 13'h1fff;
    tick();
    jump = 1'b0;
    tick();
    n_checks++;
    if (instr_pc !== 13'h1fff || prom_addr !== 13'h0) begin
      n_fail++; $display("FAIL pc_wrap: got pc=%h addr=%h want 1fff/0", instr_pc, prom_addr);
    end
    tick();
    n_checks++;
    if (instr_pc !== 13'h0) begin n_fail++; $display("FAIL pc_wrap_fetch: got %h want 0", instr_pc); end
    call = 1'b1; jaddr = 13'h123; rst = 1'b1;
    tick();
    call = 1'b0; rst = 1'b0;
    n_checks++;
    if (prom_addr !== 13'h0 || valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_on_call: got addr=%h v=%b err=%b want 0/0/0", prom_addr, valid, err);
    end
    tick();
    ret = 1'b1;
    tick();
    ret = 1'b0;
    n_checks++;
    if (err !== 1'b1 || prom_addr !== 13'h0) begin
      n_fail++; $display("FAIL rst_stack_empty: got err=%b addr=%h want 1/0", err, prom_addr);
    end
    tick();
  endtask

  task automatic test_random();
    int r;
    rom_key = 15'($urandom);
    for (int i = 0; i < 800; i++) begin
      r     = $urandom_range(0, 19);
      rst   = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 3) == 0);
      ret   = (r < 3) || (r == 10);
      call  = (r >= 3 && r < 8) || (r == 10) || (r == 11);
      jump  = (r == 8) || (r == 10) || (r == 11);
      jaddr = 13'($urandom);
      tick();
      n_checks++;
      if (prom_addr !== m_pc || instr !== m_instr || instr_pc !== m_ipc ||
          valid !== m_valid || err !== m_err) begin
        n_fail++;
        $display("FAIL random[%0d]: got addr=%h instr=%h pc=%h v=%b err=%b want %h/%h/%h/%b/%b",
                 i, prom_addr, instr, instr_pc, valid, err, m_pc, m_instr, m_ipc, m_valid, m_err);
      end
    end
    rst = 1'b0; stall = 1'b0; ret = 1'b0; call = 1'b0; jump = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    jaddr = '0; rom_key = '0;
    m_pc = '0; m_ipc = '0; m_instr = '0; m_valid = 1'b0; m_err = 1'b0; m_fill = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_call_ret();
    test_nested();
    test_edge_cases();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
